swervolf_sevenseg_ctrl: RTL and testbench
=========================================

Name: swervolf_sevenseg_ctrl

Overview:
Wishbone slave that drives the Nexys A7 eight-digit, common-anode seven-segment display. It sits inside swervolf_core on the peripheral Wishbone bus and produces the AN and Digits_Bits pins consumed by the board toplevel. It time-multiplexes eight digits from software-written registers, with hex decode or raw segment mode, per-digit enables and an anti-ghosting blank interval.

Parameters:
CLK_FREQ_HZ, 50_000_000, frequency of clk.
REFRESH_HZ, 1000, full-frame refresh rate; DIV = CLK_FREQ_HZ/(REFRESH_HZ*8) clk cycles per digit slot; DIV > BLANK_CYCLES and DIV >= 2 are required.
BLANK_CYCLES, 4, cycles at the start of each slot with all AN high.

Ports:
clk  in  1  core clock
rstn  in  1  asynchronous active-low reset
i_wb_adr  in  3  word address (byte address [4:2])
i_wb_dat  in  32  write data
i_wb_sel  in  4  byte enables
i_wb_we  in  1  write enable
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
o_wb_dat  out  32  read data
o_wb_ack  out  1  acknowledge
AN  out  8  digit anodes, active low, bit n = digit n
Digits_Bits  out  7  {CA,CB,CC,CD,CE,CF,CG}, active low

Behaviour:
- Reset (rstn low, async): all registers 0, prescaler 0, idx 0, o_wb_ack 0, o_wb_dat 0, AN 8'hFF, Digits_Bits 7'h7F. Deassertion is synchronous to clk.
- Registers (word addr):
  - 0 DIGITS: nibble n = hex value for digit n.
  - 1 ENABLE: [7:0] per-digit enable.
  - 2 CTRL: [0] RAW mode.
  - 3 RAW_LO: byte n[6:0] = segments for digit n (n=0..3), 1 = lit, bit6 = CA.
  - 4 RAW_HI: same layout for digits 4..7.
  - 5 STATUS (RO): [2:0] idx, [3] blank-interval active.
  - 6,7: read 0, writes ignored.
  - Unused bits read 0.
- Wishbone:
  - On a rising edge with cyc&stb&!o_wb_ack: writes commit per i_wb_sel byte lane, o_wb_dat is loaded, o_wb_ack goes 1 for exactly one cycle.
  - Back-to-back strobes are acked every other cycle.
  - Every address is acked; there is no error response.
  - Writes to STATUS are ignored.
- Scan:
  - Prescaler counts 0..DIV-1. At DIV-1 it wraps to 0 and idx increments (7 wraps to 0).
  - Blank is active while prescaler < BLANK_CYCLES.
- Output pipeline: one register stage, so AN and Digits_Bits reflect idx, prescaler and register state sampled on the previous edge.
  - AN = 8'hFF if blank or !ENABLE[idx]; otherwise ~(1<<idx).
  - Digits_Bits = 7'h7F if blank or digit disabled.
  - RAW mode: Digits_Bits = ~raw byte[6:0].
  - Hex mode: Digits_Bits = decode(nibble).
- Hex decode (active low, CA..CG):
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110
  - 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000
  - C 0110001, d 1000010, E 0110000, F 0111000
- Write latency: a register written on edge t affects pins from edge t+1.
- Mid-slot changes: a write during a slot affects that slot immediately; the scan is not restarted.
- Scan independence: scanning continues regardless of bus activity.
- Mid-operation reset: all outputs return to reset values asynchronously and the scan restarts at idx 0.
- Exactly one AN bit is ever low, and never during blank.

Test Plan:
- Reset value: params 800/10/BLANK 4 (DIV=10); hold rstn low → AN=FF, Digits_Bits=7F, o_wb_ack=0. Release, ENABLE=0 → AN stays FF for 200 cycles.
- Hex scan: DIGITS=0x76543210, ENABLE=FF → each slot shows 4 cycles AN=FF, then 6 cycles AN=~(1<<n) with the decode of n; digit 1 = 1001111; 7→0 wrap after 80 cycles.
- Enable mask: ENABLE=0x05 → only AN=FE (digit 0) and FB (digit 2) ever appear; other slots show FF/7F.
- Raw mode: CTRL=1, RAW_LO=0x0000007F, ENABLE=01 → digit 0 Digits_Bits=0000000. RAW_LO byte0=0x40 → 0111111.
- Bus: write DIGITS 0xFFFFFFFF with sel=0010 onto 0 → readback 0x0000FF00; ack exactly 1 cycle; read addr 6 → 0; write STATUS → no change; held stb → ack every 2nd cycle.
- Async reset mid-slot (idx=5): rstn low off-edge → AN=FF immediately; after release STATUS[2:0]=0 and registers=0.

Source files
------------

// File: rtl/swervolf_sevenseg_ctrl.sv
// Wishbone-mapped controller for the eight-digit common-anode seven-segment display.
// Scans one digit per slot with a leading blank interval; supports hex decode or raw segments.
module swervolf_sevenseg_ctrl #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int REFRESH_HZ   = 1000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic [7:0]  AN,
  output logic [6:0]  Digits_Bits
);

  localparam int DIV = CLK_FREQ_HZ / (REFRESH_HZ * 8);
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

  logic [31:0]   digits_r;
  logic [7:0]    enable_r;
  logic          raw_mode_r;
  logic [31:0]   raw_lo_r;
  logic [31:0]   raw_hi_r;
  logic [PW-1:0] presc_r;
  logic [2:0]    idx_r;

  logic          bus_req_s;
  logic          blank_s;
  logic          digit_on_s;
  logic [3:0]    nibble_s;
  logic [6:0]    raw_seg_s;
  logic [31:0]   rdata_s;
  logic [7:0]    an_next_s;
  logic [6:0]    seg_next_s;

  // Active-low segment pattern {CA..CG} for a hex nibble
  function automatic logic [6:0] hex_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      4'hF:    s = 7'b0111000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Read mux and per-slot segment/anode selection
  always_comb begin
    bus_req_s  = i_wb_cyc && i_wb_stb && !o_wb_ack;
    blank_s    = (presc_r < BLANK_END);
    digit_on_s = !blank_s && enable_r[idx_r];
    nibble_s   = digits_r[{idx_r, 2'b00} +: 4];
    if (idx_r[2]) begin
      raw_seg_s = raw_hi_r[{idx_r[1:0], 3'b000} +: 7];
    end else begin
      raw_seg_s = raw_lo_r[{idx_r[1:0], 3'b000} +: 7];
    end
    case (i_wb_adr)
      3'd0:    rdata_s = digits_r;
      3'd1:    rdata_s = {24'h000000, enable_r};
      3'd2:    rdata_s = {31'h00000000, raw_mode_r};
      3'd3:    rdata_s = raw_lo_r;
      3'd4:    rdata_s = raw_hi_r;
      3'd5:    rdata_s = {28'h0000000, blank_s, idx_r};
      default: rdata_s = 32'h00000000;
    endcase
    if (!digit_on_s) begin
      an_next_s  = 8'hFF;
      seg_next_s = 7'h7F;
    end else if (raw_mode_r) begin
      an_next_s  = ~(8'h01 << idx_r);
      seg_next_s = ~raw_seg_s;
    end else begin
      an_next_s  = ~(8'h01 << idx_r);
      seg_next_s = hex_decode(nibble_s);
    end
  end

  // Wishbone slave: single-cycle ack, byte-lane writes, registered read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_wb_ack   <= 1'b0;
      o_wb_dat   <= 32'h00000000;
      digits_r   <= 32'h00000000;
      enable_r   <= 8'h00;
      raw_mode_r <= 1'b0;
      raw_lo_r   <= 32'h00000000;
      raw_hi_r   <= 32'h00000000;
    end else if (bus_req_s) begin
      o_wb_ack <= 1'b1;
      o_wb_dat <= rdata_s;
      if (i_wb_we) begin
        case (i_wb_adr)
          3'd0: begin
            for (int n = 0; n < 4; n++) begin
              if (i_wb_sel[n]) digits_r[8*n +: 8] <= i_wb_dat[8*n +: 8];
            end
          end
          3'd1: if (i_wb_sel[0]) enable_r <= i_wb_dat[7:0];
          3'd2: if (i_wb_sel[0]) raw_mode_r <= i_wb_dat[0];
          // Bit 7 of each raw byte is kept at zero so it reads back as 0
          3'd3: begin
            for (int n = 0; n < 4; n++) begin
              if (i_wb_sel[n]) raw_lo_r[8*n +: 8] <= {1'b0, i_wb_dat[8*n +: 7]};
            end
          end
          3'd4: begin
            for (int n = 0; n < 4; n++) begin
              if (i_wb_sel[n]) raw_hi_r[8*n +: 8] <= {1'b0, i_wb_dat[8*n +: 7]};
            end
          end
          default: ;
        endcase
      end
    end else begin
      o_wb_ack <= 1'b0;
    end
  end

  // Slot prescaler and digit index
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc_r <= '0;
      idx_r   <= 3'd0;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= '0;
      idx_r   <= idx_r + 3'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Registered display pins
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      AN          <= 8'hFF;
      Digits_Bits <= 7'h7F;
    end else begin
      AN          <= an_next_s;
      Digits_Bits <= seg_next_s;
    end
  end

endmodule

// File: tb/tb_swervolf_sevenseg_ctrl.sv
// Self-checking bench for swervolf_sevenseg_ctrl: bus vector table, directed scan cases,
// and randomized bus traffic scored against a cycle-count based display model.
module tb_swervolf_sevenseg_ctrl;

  localparam int DIV   = 10;
  localparam int BLANK = 4;

  localparam logic [6:0] HEX_TAB [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  logic        clk;
  logic        rstn;
  logic [2:0]  i_wb_adr;
  logic [31:0] i_wb_dat;
  logic [3:0]  i_wb_sel;
  logic        i_wb_we;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic [31:0] o_wb_dat;
  logic        o_wb_ack;
  logic [7:0]  AN;
  logic [6:0]  Digits_Bits;

  int checks = 0;
  int errors = 0;

  swervolf_sevenseg_ctrl #(
    .CLK_FREQ_HZ(800), .REFRESH_HZ(10), .BLANK_CYCLES(BLANK)
  ) dut (
    .clk(clk), .rstn(rstn),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
    .AN(AN), .Digits_Bits(Digits_Bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          sc;  // clock edges since reset release
  logic [31:0] m_digits, m_lo, m_hi;
  logic [7:0]  m_en;
  logic        m_raw;
  logic        exp_ack;
  logic [31:0] exp_dat;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (sel[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  function automatic logic [7:0] model_an(input int c, input logic [7:0] en);
    int p, d;
    p = c % DIV;
    d = (c / DIV) % 8;
    if (p < BLANK || !en[d]) return 8'hFF;
    return ~(8'h01 << d);
  endfunction

  function automatic logic [6:0] model_seg(input int c, input logic [7:0] en, input logic raw,
                                           input logic [31:0] dg, input logic [31:0] lo,
                                           input logic [31:0] hi);
    int p, d;
    logic [31:0] t;
    p = c % DIV;
    d = (c / DIV) % 8;
    if (p < BLANK || !en[d]) return 7'h7F;
    if (raw) begin
      t = (d < 4) ? (lo >> (8 * d)) : (hi >> (8 * (d - 4)));
      return ~t[6:0];
    end
    t = (dg >> (4 * d)) & 32'h0000000F;
    return HEX_TAB[t[3:0]];
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a, input int c);
    logic [31:0] st;
    st = 32'h00000000;
    st[2:0] = 3'((c / DIV) % 8);
    st[3]   = ((c % DIV) < BLANK);
    case (a)
      3'd0:    return m_digits;
      3'd1:    return {24'h000000, m_en};
      3'd2:    return {31'h00000000, m_raw};
      3'd3:    return m_lo;
      3'd4:    return m_hi;
      3'd5:    return st;
      default: return 32'h00000000;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sc <= 0; m_digits <= 32'h0; m_lo <= 32'h0; m_hi <= 32'h0; m_en <= 8'h00;
      m_raw <= 1'b0; exp_ack <= 1'b0; exp_dat <= 32'h0; exp_an <= 8'hFF; exp_seg <= 7'h7F;
    end else begin
      exp_an  <= model_an(sc, m_en);
      exp_seg <= model_seg(sc, m_en, m_raw, m_digits, m_lo, m_hi);
      if (i_wb_cyc && i_wb_stb && !exp_ack) begin
        exp_ack <= 1'b1;
        exp_dat <= model_read(i_wb_adr, sc);
        if (i_wb_we) begin
          case (i_wb_adr)
            3'd0: m_digits <= merge(m_digits, i_wb_dat, i_wb_sel);
            3'd1: if (i_wb_sel[0]) m_en <= i_wb_dat[7:0];
            3'd2: if (i_wb_sel[0]) m_raw <= i_wb_dat[0];
            3'd3: m_lo <= merge(m_lo, i_wb_dat, i_wb_sel) & 32'h7F7F7F7F;
            3'd4: m_hi <= merge(m_hi, i_wb_dat, i_wb_sel) & 32'h7F7F7F7F;
            default: ;
          endcase
        end
      end else begin
        exp_ack <= 1'b0;
      end
      sc <= sc + 1;
    end
  end

  // Continuous scoreboard, sampled on the inactive edge
  always @(negedge clk) begin
    check("an", {24'h0, AN}, {24'h0, exp_an});
    check("seg", {25'h0, Digits_Bits}, {25'h0, exp_seg});
    check("ack", {31'h0, o_wb_ack}, {31'h0, exp_ack});
    if (exp_ack) check("rdat", o_wb_dat, exp_dat);
  end

  // ---------------- stimulus helpers ----------------
  task automatic xfer(input logic [2:0] adr, input logic we, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = 32'h0;
    @(negedge clk);
    i_wb_adr = adr; i_wb_we = we; i_wb_dat = dat; i_wb_sel = sel;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (o_wb_ack) begin
        got = 1'b1;
        rd  = o_wb_dat;
        break;
      end
    end
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
    if (!got) check("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic wait_an(input logic [7:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (AN === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  typedef struct {
    logic [2:0]  adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t        vt [20];
  logic [31:0] rd;
  bit          ok;
  bit          bad_an, saw_fe, saw_fb;

  initial begin
    vt[0]  = '{3'd0, 1'b1, 32'hFFFFFFFF, 4'b0010, 1'b0, 32'h0};
    vt[1]  = '{3'd0, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h0000FF00};
    vt[2]  = '{3'd0, 1'b1, 32'h12345678, 4'b0101, 1'b0, 32'h0};
    vt[3]  = '{3'd0, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h0034FF78};
    vt[4]  = '{3'd1, 1'b1, 32'h000001A5, 4'b0001, 1'b0, 32'h0};
    vt[5]  = '{3'd1, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h000000A5};
    vt[6]  = '{3'd1, 1'b1, 32'hFFFFFFFF, 4'b1110, 1'b0, 32'h0};
    vt[7]  = '{3'd1, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h000000A5};
    vt[8]  = '{3'd2, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0};
    vt[9]  = '{3'd2, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h00000001};
    vt[10] = '{3'd3, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0};
    vt[11] = '{3'd3, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h7F7F7F7F};
    vt[12] = '{3'd4, 1'b1, 32'h80402010, 4'b1100, 1'b0, 32'h0};
    vt[13] = '{3'd4, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h00400000};
    vt[14] = '{3'd6, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0};
    vt[15] = '{3'd6, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h00000000};
    vt[16] = '{3'd5, 1'b1, 32'hFFFFFFFF, 4'b1111, 1'b0, 32'h0};
    vt[17] = '{3'd2, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h00000001};
    vt[18] = '{3'd2, 1'b1, 32'h00000000, 4'b1111, 1'b0, 32'h0};
    vt[19] = '{3'd2, 1'b0, 32'h0,        4'b1111, 1'b1, 32'h00000000};

    i_wb_adr = 3'd0; i_wb_dat = 32'h0; i_wb_sel = 4'h0;
    i_wb_we = 1'b0; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    rstn = 1'b1;
    #3 rstn = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_an", {24'h0, AN}, 32'h000000FF);
    check("rst_seg", {25'h0, Digits_Bits}, 32'h0000007F);
    check("rst_ack", {31'h0, o_wb_ack}, 32'h0);
    check("rst_dat", o_wb_dat, 32'h0);
    rstn = 1'b1;
    repeat (200) @(negedge clk);

    // bus register table
    for (int i = 0; i < 20; i++) begin
      xfer(vt[i].adr, vt[i].we, vt[i].dat, vt[i].sel, rd);
      if (vt[i].chk) check($sformatf("vec%0d", i), rd, vt[i].exp);
    end

    // hex scan of all digits
    xfer(3'd0, 1'b1, 32'h76543210, 4'hF, rd);
    xfer(3'd1, 1'b1, 32'h000000FF, 4'hF, rd);
    wait_an(8'hFD, ok);
    check("digit1_seen", {31'h0, ok}, 32'h1);
    check("digit1_seg", {25'h0, Digits_Bits}, {25'h0, 7'b1001111});
    repeat (200) @(negedge clk);

    // enable mask
    xfer(3'd1, 1'b1, 32'h00000005, 4'hF, rd);
    bad_an = 1'b0; saw_fe = 1'b0; saw_fb = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (AN == 8'hFE) saw_fe = 1'b1;
      else if (AN == 8'hFB) saw_fb = 1'b1;
      else if (AN != 8'hFF) bad_an = 1'b1;
    end
    check("mask_only_0_2", {29'h0, bad_an, saw_fe, saw_fb}, 32'h3);

    // raw mode
    xfer(3'd2, 1'b1, 32'h00000001, 4'hF, rd);
    xfer(3'd3, 1'b1, 32'h0000007F, 4'hF, rd);
    xfer(3'd1, 1'b1, 32'h00000001, 4'hF, rd);
    wait_an(8'hFE, ok);
    check("raw_all_seen", {31'h0, ok}, 32'h1);
    check("raw_all_seg", {25'h0, Digits_Bits}, 32'h00000000);
    xfer(3'd3, 1'b1, 32'h00000040, 4'h1, rd);
    wait_an(8'hFE, ok);
    check("raw_ca_seen", {31'h0, ok}, 32'h1);
    check("raw_ca_seg", {25'h0, Digits_Bits}, {25'h0, 7'b0111111});

    // held strobe: ack every other cycle
    @(negedge clk);
    i_wb_adr = 3'd0; i_wb_we = 1'b0; i_wb_sel = 4'hF; i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("held_ack%0d", i), {31'h0, o_wb_ack}, {31'h0, (i % 2 == 0)});
    end
    @(negedge clk);
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;

    // randomized bus traffic against the model
    for (int i = 0; i < 300; i++) begin
      xfer(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom,
           4'($urandom_range(0, 15)), rd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // asynchronous reset in the middle of digit 5's slot
    xfer(3'd2, 1'b1, 32'h00000000, 4'hF, rd);
    xfer(3'd1, 1'b1, 32'h000000FF, 4'hF, rd);
    wait_an(8'hDF, ok);
    check("idx5_seen", {31'h0, ok}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("async_an", {24'h0, AN}, 32'h000000FF);
    check("async_seg", {25'h0, Digits_Bits}, 32'h0000007F);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    xfer(3'd5, 1'b0, 32'h0, 4'hF, rd);
    check("post_rst_idx", {29'h0, rd[2:0]}, 32'h0);
    xfer(3'd0, 1'b0, 32'h0, 4'hF, rd);
    check("post_rst_digits", rd, 32'h0);
    xfer(3'd1, 1'b0, 32'h0, 4'hF, rd);
    check("post_rst_enable", rd, 32'h0);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
